// File: rtl/hilo_unit_if.sv
// hilo_unit_if: request/response bundle between the execute stage and the
// HI/LO register unit.
//   req_valid, req_op, hi_in, lo_in : request from the pipeline (master)
//   req_ready                       : unit can accept a request this cycle
//   hi_out, lo_out                  : HI/LO read values for MFHI/MFLO
//   commit                          : HI and/or LO written at end of cycle
interface hilo_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic [2:0]        req_op;
  logic [DATA_W-1:0] hi_in;
  logic [DATA_W-1:0] lo_in;
  logic              req_ready;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic              commit;

  modport master (
    output req_valid, req_op, hi_in, lo_in,
    input  req_ready, hi_out, lo_out, commit
  );

  modport slave (
    input  req_valid, req_op, hi_in, lo_in,
    output req_ready, hi_out, lo_out, commit
  );
endinterface

// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO register pair in the execute stage.
// Commits WRITE/MTHI/MTLO in one cycle and performs MADD/MSUB as a two-cycle
// carry-chained 64-bit add/sub (low half first, then high half).
// Ports:
//   clk     : clock, rising edge
//   resetn  : synchronous active-low reset, highest priority
//   flushE  : execute-stage flush, drops/aborts the uncommitted operation
//   bus     : hilo_unit_if.slave (req_valid, req_op, hi_in, lo_in,
//             req_ready, hi_out, lo_out, commit)
// Optional macro HILO_FWD_EN: hi_out/lo_out bypass the value being committed
// in the current cycle; when undefined they show the stored registers only.
module hilo_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flushE,
  hilo_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_WRITE = 3'd1,
    OP_MADD  = 3'd2,
    OP_MSUB  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  state_t            state;
  logic              ready_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] lat_hi;
  logic [DATA_W-1:0] lat_lo;
  logic [DATA_W-1:0] lo_sum;
  logic              acc_sub;
  logic              carry;

  logic              op_valid;
  logic              accept;
  logic              is_acc_op;
  logic [DATA_W:0]   lo_acc;
  logic [DATA_W-1:0] hi_acc;
  logic [DATA_W-1:0] hi_next;
  logic [DATA_W-1:0] lo_next;
  logic              hi_we;
  logic              lo_we;

  always_comb begin
    op_valid  = (bus.req_op >= OP_WRITE) && (bus.req_op <= OP_MTLO);
    accept    = (state == IDLE) && bus.req_valid && !flushE && op_valid;
    is_acc_op = (bus.req_op == OP_MADD) || (bus.req_op == OP_MSUB);

    // Bit DATA_W is the carry (add) or borrow (sub) into the high half.
    if (acc_sub)
      lo_acc = {1'b0, lo_q} - {1'b0, lat_lo};
    else
      lo_acc = {1'b0, lo_q} + {1'b0, lat_lo};

    if (acc_sub)
      hi_acc = hi_q - lat_hi - {{(DATA_W-1){1'b0}}, carry};
    else
      hi_acc = hi_q + lat_hi + {{(DATA_W-1){1'b0}}, carry};

    hi_we   = 1'b0;
    lo_we   = 1'b0;
    hi_next = hi_q;
    lo_next = lo_q;

    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (bus.req_op)
            OP_WRITE: begin
              hi_we   = 1'b1;
              lo_we   = 1'b1;
              hi_next = bus.hi_in;
              lo_next = bus.lo_in;
            end
            OP_MTHI: begin
              hi_we   = 1'b1;
              hi_next = bus.hi_in;
            end
            OP_MTLO: begin
              lo_we   = 1'b1;
              lo_next = bus.lo_in;
            end
            default: ;
          endcase
        end
      end
      ACC_HI: begin
        if (!flushE) begin
          hi_we   = 1'b1;
          lo_we   = 1'b1;
          hi_next = hi_acc;
          lo_next = lo_sum;
        end
      end
      default: ;
    endcase

    // Reset wins over any write, so nothing is reported as committed.
    hi_we = hi_we && resetn;
    lo_we = lo_we && resetn;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      hi_q    <= '0;
      lo_q    <= '0;
      lat_hi  <= '0;
      lat_lo  <= '0;
      lo_sum  <= '0;
      acc_sub <= 1'b0;
      carry   <= 1'b0;
    end else begin
      if (hi_we) hi_q <= hi_next;
      if (lo_we) lo_q <= lo_next;

      unique case (state)
        IDLE: begin
          if (accept && is_acc_op) begin
            lat_hi  <= bus.hi_in;
            lat_lo  <= bus.lo_in;
            acc_sub <= (bus.req_op == OP_MSUB);
            state   <= ACC_LO;
            ready_q <= 1'b0;
          end
        end
        ACC_LO: begin
          if (flushE) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end else begin
            lo_sum <= lo_acc[DATA_W-1:0];
            carry  <= lo_acc[DATA_W];
            state  <= ACC_HI;
          end
        end
        ACC_HI: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.commit    = hi_we || lo_we;

`ifdef HILO_FWD_EN
  assign bus.hi_out = hi_we ? hi_next : hi_q;
  assign bus.lo_out = lo_we ? lo_next : lo_q;
`else
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed-vector scoreboard bench for hilo_unit.
// Stimulus pushes the expected {HI,LO} of every committing request; the
// monitor pops one entry per observed commit and checks the outputs in the
// cycle after the commit edge. Control behaviour (ready, commit, flush, reset)
// is checked inline by the stimulus process.
module tb_hilo_unit;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_MADD  = 3'd2;
  localparam logic [2:0] OP_MSUB  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic clk;
  logic resetn;
  logic flushE;

  hilo_unit_if #(.DATA_W(32)) bus ();

  hilo_unit #(.DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flushE (flushE),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_bad;
  logic [63:0] exp_q [$];
  logic        pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [2:0] op,
                         input logic [31:0] hi, input logic [31:0] lo);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.hi_in     = hi;
    bus.lo_in     = lo;
  endtask

  // Monitor: every commit consumes one expected entry; values are compared
  // one cycle later, when they are visible in both build variants.
  always @(negedge clk) begin
    if (pend) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      chk("post_commit_hi", bus.hi_out, e[63:32]);
      chk("post_commit_lo", bus.lo_out, e[31:0]);
      pend = 1'b0;
    end
    if (bus.commit === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_commit: got commit=1 expected commit=0");
      end else begin
        pend = 1'b1;
      end
    end
  end

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    pend   = 1'b0;
    resetn = 1'b0;
    flushE = 1'b0;
    set_req(1'b0, OP_NONE, '0, '0);
    cyc();
    cyc();
    chk("reset_hi", bus.hi_out, 32'h0);
    chk("reset_lo", bus.lo_out, 32'h0);
    chk("reset_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("reset_commit", {31'b0, bus.commit}, 32'd0);
    resetn = 1'b1;
    cyc();

    // WRITE: commit in accept cycle, values next cycle
    set_req(1'b1, OP_WRITE, 32'h12345678, 32'h9ABCDEF0);
    exp_q.push_back(64'h12345678_9ABCDEF0);
    #1;
    chk("write_commit", {31'b0, bus.commit}, 32'd1);
    cyc();
    set_req(1'b0, OP_NONE, '0, '0);
    chk("write_hi", bus.hi_out, 32'h12345678);
    chk("write_lo", bus.lo_out, 32'h9ABCDEF0);
    chk("write_ready", {31'b0, bus.req_ready}, 32'd1);

    // MADD with carry across halves
    set_req(1'b1, OP_WRITE, 32'h00000001, 32'hFFFFFFFF);
    exp_q.push_back(64'h00000001_FFFFFFFF);
    cyc();
    set_req(1'b1, OP_MADD, 32'h00000000, 32'h00000001);
    exp_q.push_back(64'h00000002_00000000);
    cyc();
    set_req(1'b0, OP_NONE, '0, '0);
    chk("madd_ready_k1", {31'b0, bus.req_ready}, 32'd0);
    chk("madd_nocommit_acclo", {31'b0, bus.commit}, 32'd0);
    cyc();
    chk("madd_ready_k2", {31'b0, bus.req_ready}, 32'd0);
    chk("madd_commit_acchi", {31'b0, bus.commit}, 32'd1);
    cyc();
    chk("madd_ready_after", {31'b0, bus.req_ready}, 32'd1);
    chk("madd_hi", bus.hi_out, 32'h00000002);
    chk("madd_lo", bus.lo_out, 32'h00000000);

    // MSUB with borrow and 64-bit wrap
    set_req(1'b1, OP_WRITE, 32'h00000000, 32'h00000001);
    exp_q.push_back(64'h00000000_00000001);
    cyc();
    set_req(1'b1, OP_MSUB, 32'h00000000, 32'h00000002);
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFF);
    cyc();
    set_req(1'b0, OP_NONE, '0, '0);
    cyc();
    cyc();
    chk("msub_hi", bus.hi_out, 32'hFFFFFFFF);
    chk("msub_lo", bus.lo_out, 32'hFFFFFFFF);

    // Flush during ACC_HI aborts; flushed request is dropped
    set_req(1'b1, OP_WRITE, 32'hAAAA0000, 32'h00005555);
    exp_q.push_back(64'hAAAA0000_00005555);
    cyc();
    set_req(1'b1, OP_MADD, 32'h00000001, 32'h00000001);
    cyc();
    set_req(1'b0, OP_NONE, '0, '0);
    cyc();
    flushE = 1'b1;
    #1;
    chk("flush_acchi_commit", {31'b0, bus.commit}, 32'd0);
    cyc();
    flushE = 1'b0;
    chk("flush_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("flush_hi", bus.hi_out, 32'hAAAA0000);
    chk("flush_lo", bus.lo_out, 32'h00005555);
    flushE = 1'b1;
    set_req(1'b1, OP_WRITE, 32'h0000DEAD, 32'h0000BEEF);
    #1;
    chk("flush_req_commit", {31'b0, bus.commit}, 32'd0);
    cyc();
    flushE = 1'b0;
    set_req(1'b0, OP_NONE, '0, '0);
    chk("flush_req_hi", bus.hi_out, 32'hAAAA0000);
    chk("flush_req_ready", {31'b0, bus.req_ready}, 32'd1);

    // MTLO / MTHI write only their register
    set_req(1'b1, OP_WRITE, 32'h11111111, 32'h00000000);
    exp_q.push_back(64'h11111111_00000000);
    cyc();
    set_req(1'b1, OP_MTLO, 32'h22222222, 32'hDEADBEEF);
    exp_q.push_back(64'h11111111_DEADBEEF);
    #1;
    chk("mtlo_commit", {31'b0, bus.commit}, 32'd1);
    chk("mtlo_hi_commit_cycle", bus.hi_out, 32'h11111111);
`ifdef HILO_FWD_EN
    chk("mtlo_lo_commit_cycle", bus.lo_out, 32'hDEADBEEF);
`else
    chk("mtlo_lo_commit_cycle", bus.lo_out, 32'h00000000);
`endif
    cyc();
    chk("mtlo_lo", bus.lo_out, 32'hDEADBEEF);
    chk("mtlo_hi", bus.hi_out, 32'h11111111);
    set_req(1'b1, OP_MTHI, 32'hCAFEF00D, 32'h33333333);
    exp_q.push_back(64'hCAFEF00D_DEADBEEF);
    cyc();

    // Undefined opcode is ignored
    set_req(1'b1, 3'd6, 32'h44444444, 32'h55555555);
    #1;
    chk("op6_commit", {31'b0, bus.commit}, 32'd0);
    cyc();
    set_req(1'b0, OP_NONE, '0, '0);
    chk("op6_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("op6_hi", bus.hi_out, 32'hCAFEF00D);

    // Back-to-back MADDs: second reads the freshly committed value
    set_req(1'b1, OP_WRITE, 32'h00000000, 32'hFFFFFFFF);
    exp_q.push_back(64'h00000000_FFFFFFFF);
    cyc();
    set_req(1'b1, OP_MADD, 32'h00000000, 32'h00000001);
    exp_q.push_back(64'h00000001_00000000);
    cyc();
    set_req(1'b0, OP_NONE, '0, '0);
    cyc();
    cyc();
    set_req(1'b1, OP_MADD, 32'h00000000, 32'h00000001);
    exp_q.push_back(64'h00000001_00000001);
    #1;
    chk("b2b_ready", {31'b0, bus.req_ready}, 32'd1);
    cyc();
    set_req(1'b0, OP_NONE, '0, '0);
    cyc();
    cyc();
    chk("b2b_hi", bus.hi_out, 32'h00000001);
    chk("b2b_lo", bus.lo_out, 32'h00000001);

    // Reset during ACC_LO discards the accumulation
    set_req(1'b1, OP_MADD, 32'h00000005, 32'h00000005);
    cyc();
    set_req(1'b0, OP_NONE, '0, '0);
    resetn = 1'b0;
    #1;
    chk("rst_acclo_commit", {31'b0, bus.commit}, 32'd0);
    cyc();
    resetn = 1'b1;
    chk("rst_acclo_hi", bus.hi_out, 32'h0);
    chk("rst_acclo_lo", bus.lo_out, 32'h0);
    chk("rst_acclo_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_acclo_commit_after", {31'b0, bus.commit}, 32'd0);
    cyc();
    cyc();
    chk("rst_acclo_hi_later", bus.hi_out, 32'h0);

    for (int i = 0; i < 10 && (exp_q.size() != 0 || pend); i++) cyc();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Architectural HI/LO register pair in the execute stage, directly downstream of the multicycle mult/div unit.
- Commits MULT/MULTU/DIV/DIVU results and MTHI/MTLO writes.
- Performs MADD/MADDU/MSUB/MSUBU 64-bit accumulation as a two-cycle, carry-chained 32-bit add/sub.
- Provides HI/LO read values to MFHI/MFLO and a ready handshake that stalls the pipeline while an accumulation is in flight.

Parameters:
- DATA_W, 32, width of HI, LO and each operand half; the accumulated value is 2*DATA_W bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  synchronous, active-low reset.
- flushE  input  1  execute-stage flush; aborts the uncommitted operation.
- req_valid  input  1  request presented this cycle (the multicycle unit's ok qualifies product/quotient ops).
- req_op  input  3  0 NONE, 1 WRITE (HI<=hi_in, LO<=lo_in), 2 MADD, 3 MSUB, 4 MTHI (HI<=hi_in), 5 MTLO (LO<=lo_in); 6-7 treated as NONE.
- hi_in  input  DATA_W  high half of product/remainder, or MTHI source.
- lo_in  input  DATA_W  low half of product/quotient, or MTLO source.
- req_ready  output  1  unit can accept a request this cycle.
- hi_out  output  DATA_W  HI value for MFHI.
- lo_out  output  DATA_W  LO value for MFLO.
- commit  output  1  HI and/or LO are written at the end of this cycle.

Behaviour:
- Reset (resetn=0 at a rising edge): HI=0, LO=0, state=IDLE, internal latches cleared. Outputs after reset: req_ready=1, commit=0, hi_out=lo_out=0.
- States: IDLE, ACC_LO, ACC_HI.
- A request is accepted when req_valid & req_ready & ~flushE and req_op is 1-5.
- req_ready = (state==IDLE).
- IDLE:
  - WRITE, MTHI, MTLO: commit=1 in the accept cycle. Only the named register(s) update at that edge. State stays IDLE; latency 1.
  - MADD/MSUB: latch {hi_in,lo_in} and the op. Next state ACC_LO. commit=0.
- ACC_LO:
  - Compute lo_acc = LO +/- lo_in_latched as DATA_W+1 bits.
  - Register sum[DATA_W-1:0] and carry/borrow. Next state ACC_HI. commit=0.
- ACC_HI:
  - hi_acc = HI +/- hi_in_latched +/- carry/borrow.
  - commit=1. HI<=hi_acc and LO<=registered low sum, both at the same edge. Next state IDLE.
- Accumulation arithmetic:
  - Full 64-bit two's-complement add (MADD) or subtract (MSUB), wrapping modulo 2^(2*DATA_W). No overflow flag.
  - Signedness is irrelevant here: the upstream unit supplies the 64-bit product.
- Accumulation latency: accept at edge k; HI/LO hold the new values after edge k+2. req_ready is low for the two cycles between.
- HI/LO never change except at a commit edge. An aborted accumulation leaves HI/LO untouched.
- flushE:
  - Has priority over acceptance: a request in a flushE=1 cycle is dropped.
  - In ACC_LO or ACC_HI: return to IDLE, commit forced to 0, no write.
- resetn has priority over flushE and everything else, including mid-accumulation.
- req_valid with req_op NONE/6/7: ignored, no state change.
- Back-to-back: a new request may be accepted in the cycle immediately after an ACC_HI commit. That accumulation reads the freshly committed HI/LO.

Optional Feature:
- Macro: HILO_FWD_EN.
- Defined: hi_out/lo_out are combinational bypasses. When commit=1 they show the value being written this cycle, for each register written; otherwise they show the stored HI/LO. MFHI issued in the commit cycle sees the new value.
- Undefined: hi_out/lo_out are the stored registers only. New values appear one cycle after commit.

Test Plan:
- Reset, then WRITE hi_in=0x12345678 lo_in=0x9ABCDEF0 -> commit=1 in the accept cycle. Next cycle hi_out=0x12345678, lo_out=0x9ABCDEF0, req_ready=1.
- HI:LO=0x00000001_FFFFFFFF, MADD with 0x00000000_00000001 -> req_ready=0 for 2 cycles. After edge k+2, HI=0x00000002, LO=0x00000000 (carry crosses halves).
- HI:LO=0x00000000_00000001, MSUB with 0x00000000_00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF (borrow, 64-bit wrap).
- MADD accepted, flushE=1 during ACC_HI -> commit=0, HI/LO unchanged, req_ready=1 the next cycle. Also: a request presented with flushE=1 is not accepted.
- MTLO 0xDEADBEEF with HI=0x11111111 -> LO=0xDEADBEEF, HI stays 0x11111111. With HILO_FWD_EN, lo_out=0xDEADBEEF in the commit cycle; without it, one cycle later.
- resetn=0 asserted in ACC_LO after a MADD accept -> HI=LO=0, state IDLE, commit=0 at the next edge. No partial write survives.
